// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, transmitter FSM states and CRC5 constants.
package usb_pkg;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SOF   = 4'h5;
   localparam logic [3:0] PID_SETUP = 4'hD;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;

   localparam logic [4:0] CRC5_POLY = 5'b00101;
   localparam logic [4:0] CRC5_INIT = 5'b11111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_PID   = 3'd2,
      ST_TOKEN = 3'd3,
      ST_CRC   = 3'd4,
      ST_EOP   = 3'd5,
      ST_J     = 3'd6
   } usb_state_e;

   // Handshakes (ACK/NAK/STALL) share pid[1:0]==2'b10 and carry no token field.
   function automatic logic is_handshake(input logic [3:0] pid);
      return pid[1:0] == 2'b10;
   endfunction

endpackage

// File: rtl/usb_crc5.sv
// Serial USB CRC5 (x^5+x^2+1); crc_o is the inverted remainder, ready to send MSB first.
module usb_crc5
   import usb_pkg::*;
(
   input  logic       gclk,
   input  logic       reset,
   input  logic       clear_i,
   input  logic       bit_en_i,
   input  logic       bit_in_i,
   output logic [4:0] crc_o
);

   logic [4:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = crc_q[4] ^ bit_in_i;
      crc_d = {crc_q[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
   end

   always_ff @(posedge gclk) begin
      if (reset || clear_i) crc_q <= CRC5_INIT;
      else if (bit_en_i)    crc_q <= crc_d;
   end

   assign crc_o = ~crc_q;

endmodule

// File: rtl/usb_token_tx.sv
// USB token/handshake transmitter: SYNC, PID, token, CRC5, bit stuffing, NRZI, EOP.
module usb_token_tx
   import usb_pkg::*;
#(
   parameter logic [7:0] SYNC_PATTERN   = 8'h80,
   parameter int         STUFF_LIMIT    = 6,
   parameter int         EOP_SE0_CYCLES = 2
) (
   input  logic        gclk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  pid,
   input  logic [10:0] token_data,
   output logic        ready,
   output logic        nrzi_data,
   output logic        tx_data_valid,
   output logic        se0,
   output logic        done
);

   localparam int OW = $clog2(STUFF_LIMIT + 1);

   usb_state_e    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    pid_q, pid_d;
   logic [10:0]   tok_q, tok_d;
   logic [OW-1:0] ones_q, ones_d;
   logic          stuff_q, stuff_d;
   logic          line_q;

   logic [7:0] pid_byte;
   logic [4:0] crc;
   logic       in_data, raw_adv, raw_bit, cur_bit, accept;

   assign pid_byte = {~pid_q, pid_q};
   assign accept   = (state_q == ST_IDLE) && start;
   assign in_data  = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                     (state_q == ST_TOKEN) || (state_q == ST_CRC);
   // A pending stuffed bit freezes every raw-bit counter and the CRC.
   assign raw_adv  = in_data && !stuff_q;

   usb_crc5 u_crc5 (
      .gclk     (gclk),
      .reset    (reset),
      .clear_i  (accept),
      .bit_en_i (raw_adv && (state_q == ST_TOKEN)),
      .bit_in_i (raw_bit),
      .crc_o    (crc)
   );

   always_comb begin
      raw_bit = 1'b0;
      case (state_q)
         ST_SYNC:  raw_bit = SYNC_PATTERN[cnt_q[2:0]];
         ST_PID:   raw_bit = pid_byte[cnt_q[2:0]];
         ST_TOKEN: raw_bit = tok_q[cnt_q];
         ST_CRC:   raw_bit = crc[3'd4 - cnt_q[2:0]];
         default:  raw_bit = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pid_d   = pid_q;
      tok_d   = tok_q;
      ones_d  = ones_q;
      stuff_d = 1'b0;
      if (!stuff_q) begin
         if (raw_adv) begin
            if (!raw_bit) begin
               ones_d = '0;
            end else if (ones_q == OW'(STUFF_LIMIT - 1)) begin
               ones_d  = '0;
               stuff_d = 1'b1;
            end else begin
               ones_d = ones_q + 1'b1;
            end
         end
         case (state_q)
            ST_IDLE: begin
               ones_d = '0;
               if (start) begin
                  state_d = ST_SYNC;
                  cnt_d   = '0;
                  pid_d   = pid;
                  tok_d   = token_data;
               end
            end
            ST_SYNC: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == 4'd7) begin
                  state_d = ST_PID;
                  cnt_d   = '0;
               end
            end
            ST_PID: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == 4'd7) begin
                  state_d = is_handshake(pid_q) ? ST_EOP : ST_TOKEN;
                  cnt_d   = '0;
               end
            end
            ST_TOKEN: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == 4'd10) begin
                  state_d = ST_CRC;
                  cnt_d   = '0;
               end
            end
            ST_CRC: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == 4'd4) begin
                  state_d = ST_EOP;
                  cnt_d   = '0;
               end
            end
            ST_EOP: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == 4'(EOP_SE0_CYCLES - 1)) begin
                  state_d = ST_J;
                  cnt_d   = '0;
               end
            end
            ST_J:    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A stuff bit owed by the last CRC bit is still sent while the FSM sits in EOP.
   assign cur_bit       = raw_bit && !stuff_q;
   assign tx_data_valid = in_data || stuff_q;
   assign nrzi_data     = tx_data_valid ? (cur_bit ? line_q : ~line_q) : 1'b1;
   assign se0           = (state_q == ST_EOP) && !stuff_q;
   assign done          = (state_q == ST_J);
   assign ready         = (state_q == ST_IDLE);

   always_ff @(posedge gclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pid_q   <= '0;
         tok_q   <= '0;
         ones_q  <= '0;
         stuff_q <= 1'b0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pid_q   <= pid_d;
         tok_q   <= tok_d;
         ones_q  <= ones_d;
         stuff_q <= stuff_d;
         line_q  <= nrzi_data;
      end
   end

endmodule

// File: tb/tb_usb_token_tx.sv
// Directed bench for usb_token_tx: decodes NRZI, unstuffs and checks framing of each packet.
module tb_usb_token_tx;

   logic        gclk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  pid = 4'h0;
   logic [10:0] token_data = 11'h000;
   logic        ready, nrzi_data, tx_data_valid, se0, done;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] c_raw;
   int          c_nraw, c_nvalid, c_nstuff, c_stuff_err, c_nse0;
   logic        c_first, c_jdone, c_jnrzi, c_jse0, c_ready, c_end_stuff;

   usb_token_tx dut (
      .gclk          (gclk),
      .reset         (reset),
      .start         (start),
      .pid           (pid),
      .token_data    (token_data),
      .ready         (ready),
      .nrzi_data     (nrzi_data),
      .tx_data_valid (tx_data_valid),
      .se0           (se0),
      .done          (done)
   );

   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] crc5_ref(input logic [10:0] t);
      logic [4:0] c;
      logic       fb;
      c = 5'b11111;
      for (int i = 0; i < 11; i++) begin
         fb = c[4] ^ t[i];
         c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      return ~c;
   endfunction

   function automatic logic [31:0] model_raw(input logic [3:0] p, input logic [10:0] t);
      logic [31:0] r;
      logic [4:0]  c;
      c        = crc5_ref(t);
      r[7:0]   = 8'h80;
      r[15:8]  = {~p, p};
      r[26:16] = t;
      for (int k = 0; k < 5; k++) r[27+k] = c[4-k];
      return r;
   endfunction

   function automatic int stuff_cnt(input logic [31:0] r);
      int ones, cnt;
      ones = 0; cnt = 0;
      for (int i = 0; i < 32; i++) begin
         if (r[i]) begin
            ones++;
            if (ones == 6) begin cnt++; ones = 0; end
         end else ones = 0;
      end
      return cnt;
   endfunction

   function automatic logic stuff_end(input logic [31:0] r);
      int   ones;
      logic e;
      ones = 0; e = 1'b0;
      for (int i = 0; i < 32; i++) begin
         e = 1'b0;
         if (r[i]) begin
            ones++;
            if (ones == 6) begin e = 1'b1; ones = 0; end
         end else ones = 0;
      end
      return e;
   endfunction

   task automatic launch(input logic [3:0] p, input logic [10:0] t);
      for (int i = 0; i < 60 && ready !== 1'b1; i++) @(negedge gclk);
      chk("launch_ready", {31'd0, ready}, 32'd1);
      pid = p; token_data = t; start = 1'b1;
      @(negedge gclk);
      start = 1'b0;
   endtask

   // poke >= 0 raises start for one cycle mid-packet, which must be ignored.
   task automatic capture(input int poke);
      logic prev, b;
      int   ones, cyc;
      prev = 1'b1; ones = 0; cyc = 0;
      c_raw = '0; c_nraw = 0; c_nvalid = 0; c_nstuff = 0; c_stuff_err = 0; c_nse0 = 0;
      c_end_stuff = 1'b0;
      c_first = tx_data_valid;
      while (tx_data_valid === 1'b1 && cyc < 100) begin
         b = (nrzi_data == prev);
         prev = nrzi_data;
         c_nvalid++;
         if (ones == 6) begin
            c_nstuff++; ones = 0; c_end_stuff = 1'b1;
            if (b) c_stuff_err++;
         end else begin
            if (c_nraw < 32) c_raw[c_nraw] = b;
            c_nraw++;
            ones = b ? ones + 1 : 0;
            c_end_stuff = 1'b0;
         end
         start = (cyc == poke);
         @(negedge gclk);
         cyc++;
      end
      start = 1'b0;
      while (se0 === 1'b1 && cyc < 100) begin
         c_nse0++;
         @(negedge gclk);
         cyc++;
      end
      c_jdone = done; c_jnrzi = nrzi_data; c_jse0 = se0;
      @(negedge gclk);
      c_ready = ready;
   endtask

   task automatic check_pkt(input string tag, input logic [31:0] exp_raw,
                            input int exp_nraw, input int exp_nvalid);
      chk({tag, "_first_valid"}, {31'd0, c_first}, 32'd1);
      chk({tag, "_raw"}, c_raw, exp_raw);
      chk({tag, "_nraw"}, c_nraw, exp_nraw);
      chk({tag, "_nvalid"}, c_nvalid, exp_nvalid);
      chk({tag, "_stuff_err"}, c_stuff_err, 32'd0);
      chk({tag, "_se0_cycles"}, c_nse0, 32'd2);
      chk({tag, "_j_done"}, {31'd0, c_jdone}, 32'd1);
      chk({tag, "_j_nrzi"}, {31'd0, c_jnrzi}, 32'd1);
      chk({tag, "_j_se0"}, {31'd0, c_jse0}, 32'd0);
      chk({tag, "_ready_after"}, {31'd0, c_ready}, 32'd1);
   endtask

   initial begin
      int          found, dn, dv;
      logic [31:0] mr;

      repeat (3) @(negedge gclk);
      chk("rst_nrzi", {31'd0, nrzi_data}, 32'd1);
      chk("rst_valid", {31'd0, tx_data_valid}, 32'd0);
      chk("rst_se0", {31'd0, se0}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      @(negedge gclk);

      launch(4'hD, 11'h000); capture(-1);
      check_pkt("setup", 32'h10002D80, 32, 32);

      launch(4'h2, 11'h155); capture(5);
      check_pkt("ack", 32'h0000D280, 16, 16);
      // Start issued in the very cycle ready returns.
      launch(4'h1, 11'h000); capture(-1);
      check_pkt("out_b2b", 32'h1000E180, 32, 32);

      launch(4'h9, 11'h7FF); capture(-1);
      check_pkt("in7ff", 32'h47FF6980, 32, 33);
      chk("in7ff_stuffs", c_nstuff, 32'd1);

      launch(4'h5, 11'h000); capture(-1);
      check_pkt("sof000", 32'h1000A580, 32, 32);

      launch(4'h5, 11'h7FF); capture(-1);
      check_pkt("sof7ff", 32'h47FFA580, 32, 34);
      chk("sof7ff_stuffs", c_nstuff, 32'd2);

      found = -1;
      for (int t = 0; t < 2048 && found < 0; t++)
         if (stuff_end(model_raw(4'h5, 11'(t)))) found = t;
      chk("end_stuff_found", {31'd0, found >= 0}, 32'd1);
      if (found >= 0) begin
         mr = model_raw(4'h5, 11'(found));
         launch(4'h5, 11'(found)); capture(-1);
         check_pkt("sof_end", mr, 32, 32 + stuff_cnt(mr));
         chk("sof_end_stuffed", {31'd0, c_end_stuff}, 32'd1);
      end

      launch(4'h1, 11'h2A5);
      repeat (9) @(negedge gclk);
      reset = 1'b1;
      @(posedge gclk);
      #1;
      chk("abort_nrzi", {31'd0, nrzi_data}, 32'd1);
      chk("abort_valid", {31'd0, tx_data_valid}, 32'd0);
      chk("abort_se0", {31'd0, se0}, 32'd0);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      @(negedge gclk);
      reset = 1'b0;
      dn = 0; dv = 0;
      repeat (40) begin
         @(negedge gclk);
         if (done) dn++;
         if (tx_data_valid) dv++;
      end
      chk("abort_no_done", dn, 32'd0);
      chk("abort_no_tx", dv, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/usb_token_tx.md
Name: usb_token_tx

Overview:
- USB low-level packet transmitter. It is the send-side counterpart of the rx_diff field decoder.
- Takes a PID plus an 11-bit token field, builds SYNC/PID/token/CRC5/EOP, bit-stuffs, NRZI-encodes, and serializes one bit per clock.
- Its outputs nrzi_data and tx_data_valid drive tx_diff directly; se0 requests the EOP single-ended-zero.

Parameters:
- SYNC_PATTERN, 8'h80, SYNC byte, sent LSB first.
- STUFF_LIMIT, 6, consecutive raw 1s after which a stuffed 0 is inserted.
- EOP_SE0_CYCLES, 2, number of cycles se0 is held during EOP.

Ports:
- gclk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send a packet; accepted only while ready=1.
- pid  input  4  packet ID; the inverted nibble is generated internally.
- token_data  input  11  {endp[3:0],addr[6:0]} for tokens, or frame_number for SOF; sent LSB first.
- ready  output  1  idle; able to accept start.
- nrzi_data  output  1  NRZI line level (1=J) to tx_diff.
- tx_data_valid  output  1  high while SYNC..CRC bits, including stuffed bits, are on nrzi_data.
- se0  output  1  EOP single-ended-zero request to tx_diff.
- done  output  1  one-cycle pulse when the packet is complete.

Behaviour:
- Reset values: nrzi_data=1, tx_data_valid=0, se0=0, ready=1, done=0. State returns to IDLE and counters clear. Reset mid-packet aborts at the next edge with no EOP.
- Accept: start&&ready at edge N latches pid and token_data and deasserts ready. The first SYNC bit appears at N+1 with tx_data_valid=1. start while busy is ignored.
- Packet class: pid[1:0]==2'b10 is a handshake (ACK/NAK/STALL): send SYNC+PID only. Any other PID sends SYNC+PID+token+CRC5.
- FSM states: IDLE -> SYNC(8) -> PID(8) -> [TOKEN(11) -> CRC(5)] -> EOP(EOP_SE0_CYCLES) -> J(1) -> IDLE.
- PID byte: {~pid,pid}, sent LSB first.
- CRC5:
  - Polynomial x^5+x^2+1, register init 5'b11111.
  - Updated per token bit in transmit order, on raw (unstuffed) bits.
  - The inverted remainder is sent MSB first.
- Bit counters: count raw bits only. Stuffed bits stall the counters and the CRC.
- Stuffing:
  - A ones counter runs over the raw stream from SYNC through CRC. It counts a raw 1 and clears on a raw 0.
  - When it reaches STUFF_LIMIT after a raw 1, the next cycle emits a stuffed 0 and clears the counter.
  - A stuffed bit after the final CRC bit is still sent, with tx_data_valid=1, before EOP.
- NRZI: a 0 (raw or stuffed) toggles nrzi_data; a 1 holds it. Encoding starts from J=1.
- EOP: tx_data_valid=0 and se0=1 for EOP_SE0_CYCLES cycles. Then one J cycle with nrzi_data=1, se0=0 and done=1. ready rises on the following cycle.
- Wire length:
  - Token: 32 raw bits plus stuffed bits, then 3 EOP/J cycles.
  - Handshake: 16 raw bits, then 3 EOP/J cycles.
- Back-to-back: start in the cycle after ready rises begins the new SYNC immediately. No extra idle is inserted beyond the J cycle.

Decomposition:
- Package usb_pkg: PID constants (OUT=4'h1, IN=4'h9, SOF=4'h5, SETUP=4'hD, ACK=4'h2, NAK=4'hA, STALL=4'hE), the FSM state enum, CRC5_POLY=5'b00101, CRC5_INIT=5'b11111.
- Sub-module usb_crc5: serial CRC5 with clear, bit_en and bit_in inputs, and the 5-bit inverted-remainder output. It is reusable by rx_diff for checking.

Test Plan:
- SETUP (pid=4'hD), token_data=0: after NRZI-decoding and unstuffing while tx_data_valid=1, the bench sees bytes 0x80,0x2D,0x00,0x10 LSB first. Then 2 cycles se0=1, 1 J cycle with done=1, then ready=1.
- ACK (pid=4'h2): decoded bytes are 0x80,0xD2. tx_data_valid is high for exactly 16 cycles, then EOP; there are no token or CRC bits.
- IN (pid=4'h9), token_data=11'h7FF: a stuffed 0 (a toggle) appears after the 6th consecutive 1 of the token. Unstuffed output equals the reference-model CRC5. tx_data_valid length is 32 plus the model stuff count.
- Reset asserted at the 10th bit of a token packet: at the next edge nrzi_data=1, tx_data_valid=0, se0=0, ready=1, and no done pulse occurs.
- Two starts: a start during busy is ignored, so only one packet is sent. A start the cycle ready returns sends a second SYNC with no gap beyond the J cycle.
- SOF (pid=4'h5), frame_number=11'h000 and 11'h7FF: the CRC field matches the model; ones-run stuffing is checked across the CRC/EOP boundary.
